pipelined_addsub: RTL and testbench

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

---
 rtl/addsub_pkg.sv | 34 +++
 rtl/addsub_seg.sv | 14 +
 rtl/pipelined_addsub.sv | 141 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the segmented add/subtract pipeline: opcode encoding,
// per-stage control register layout and opcode decode helpers.
package addsub_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    ADDC = 2'd2,
    SUBB = 2'd3
  } op_e;

  // Control half of a stage register; operand/result data sit beside it
  // because their widths are set by the top-level parameters.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic logic op_invert_b(input op_e op);
    return (op == SUB) || (op == SUBB);
  endfunction

  function automatic logic op_carry_in(input op_e op, input logic cin);
    logic c;
    case (op)
      ADD:     c = 1'b0;
      SUB:     c = 1'b1;
      ADDC:    c = cin;
      default: c = ~cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry-chain segment: SEG-bit add with carry in and carry out.
module addsub_seg #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_addsub.sv
// W-bit add/subtract split into W/SEG carry-chain stages, one segment per
// stage, with valid/ready flow control and a tag carried alongside each op.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int W    = 64,
  parameter int SEG  = 16,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_cin,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            out_cout,
  output logic            out_ovf,
  output logic            out_zero
);

  localparam int NSTG = W / SEG;

  if ((W % SEG) != 0) begin : g_param_check
    $error("pipelined_addsub: W (%0d) must be a multiple of SEG (%0d)", W, SEG);
  end

  op_e          op;
  logic [W-1:0] eff_b;
  logic         cin0;
  logic         adv;

  stage_ctrl_t     stg_ctrl [NSTG];
  logic [W-1:0]    stg_a    [NSTG];
  logic [W-1:0]    stg_b    [NSTG];
  logic [W-1:0]    stg_y    [NSTG];
  logic [TAGW-1:0] stg_tag  [NSTG];

  assign op    = op_e'(in_op);
  assign eff_b = op_invert_b(op) ? ~in_b : in_b;
  assign cin0  = op_carry_in(op, in_cin);

  // Whole pipe moves together; it only stops when a finished result is
  // sitting at the output and downstream is not taking it.
  assign out_valid = stg_ctrl[NSTG-1].valid;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
    logic            v_src;
    logic            c_src;
    logic [W-1:0]    a_src;
    logic [W-1:0]    b_src;
    logic [W-1:0]    y_src;
    logic [TAGW-1:0] tag_src;
    logic [SEG-1:0]  seg_sum;
    logic            seg_cout;
    logic [W-1:0]    y_d;
    stage_ctrl_t     ctrl_d;
    stage_ctrl_t     ctrl_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    y_q;
    logic [TAGW-1:0] tag_q;

    if (gi == 0) begin : g_head
      assign v_src   = in_valid;
      assign c_src   = cin0;
      assign a_src   = in_a;
      assign b_src   = eff_b;
      assign y_src   = '0;
      assign tag_src = in_tag;
    end else begin : g_body
      assign v_src   = stg_ctrl[gi-1].valid;
      assign c_src   = stg_ctrl[gi-1].carry;
      assign a_src   = stg_a[gi-1];
      assign b_src   = stg_b[gi-1];
      assign y_src   = stg_y[gi-1];
      assign tag_src = stg_tag[gi-1];
    end

    addsub_seg #(
      .SEG (SEG)
    ) u_seg (
      .a_i    (a_src[gi*SEG +: SEG]),
      .b_i    (b_src[gi*SEG +: SEG]),
      .cin_i  (c_src),
      .sum_o  (seg_sum),
      .cout_o (seg_cout)
    );

    always_comb begin
      y_d                  = y_src;
      y_d[gi*SEG +: SEG]   = seg_sum;
    end

    assign ctrl_d.valid = v_src;
    assign ctrl_d.carry = seg_cout;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ctrl_q <= '0;
      end else if (adv) begin
        ctrl_q <= ctrl_d;
      end
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        a_q   <= a_src;
        b_q   <= b_src;
        y_q   <= y_d;
        tag_q <= tag_src;
      end
    end

    assign stg_ctrl[gi] = ctrl_q;
    assign stg_a[gi]    = a_q;
    assign stg_b[gi]    = b_q;
    assign stg_y[gi]    = y_q;
    assign stg_tag[gi]  = tag_q;
  end

  assign out_y    = stg_y[NSTG-1];
  assign out_tag  = stg_tag[NSTG-1];
  assign out_cout = stg_ctrl[NSTG-1].carry;
  assign out_zero = (out_y == '0);
  // Operand sign bits ride to the end so overflow is judged on the final sum.
  assign out_ovf  = (stg_a[NSTG-1][W-1] == stg_b[NSTG-1][W-1]) &&
                    (out_y[W-1] != stg_a[NSTG-1][W-1]);

  logic unused_operands;
  assign unused_operands = ^{stg_a[NSTG-1][W-2:0], stg_b[NSTG-1][W-2:0]};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub at W=64, SEG=16 (four stages).
module tb_pipelined_addsub;
  import addsub_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_y;
  logic [7:0]  out_tag;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  pipelined_addsub #(
    .W    (64),
    .SEG  (16),
    .TAGW (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [63:0] y;
    logic [7:0]  tag;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   trk_en   = 0;
  int   trk_first;
  int   trk_last;
  int   trk_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic, independent of the segment chain.
  function automatic exp_t model(input logic [1:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic cin,
                                 input logic [7:0] tag);
    exp_t        e;
    logic        c;
    logic [65:0] u;
    logic [65:0] s;
    logic [65:0] sa;
    logic [65:0] sb;
    c  = op[1] ? cin : 1'b0;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    if (!op[0]) begin
      u      = {2'b00, a} + {2'b00, b} + {65'd0, c};
      s      = sa + sb + {65'd0, c};
      e.cout = u[64];
    end else begin
      u      = {2'b00, a} - {2'b00, b} - {65'd0, c};
      s      = sa - sb - {65'd0, c};
      e.cout = ~u[65];
    end
    e.y    = u[63:0];
    e.ovf  = !((s[65] == s[64]) && (s[64] == s[63]));
    e.zero = (u[63:0] == 64'd0);
    e.tag  = tag;
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      $display("out  tag=%h y=%h cout=%b ovf=%b zero=%b", out_tag, out_y, out_cout, out_ovf, out_zero);
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_y", out_y, mon_e.y);
        check("sb_tag", 64'(out_tag), 64'(mon_e.tag));
        check("sb_cout", 64'(out_cout), 64'(mon_e.cout));
        check("sb_ovf", 64'(out_ovf), 64'(mon_e.ovf));
        check("sb_zero", 64'(out_zero), 64'(mon_e.zero));
      end
      if (trk_en) begin
        if (trk_first < 0) trk_first = cyc;
        trk_last = cyc;
        trk_cnt++;
      end
    end
    if (in_valid && in_ready) begin
      $display("in   tag=%h op=%0d a=%h b=%h cin=%b", in_tag, in_op, in_a, in_b, in_cin);
      sb_q.push_back(model(in_op, in_a, in_b, in_cin, in_tag));
    end
  end

  // Called and returns at 1 time unit after a rising edge.
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic [7:0] tag);
    int guard = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_tag   = tag;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic cin, input logic [7:0] tag,
                          input logic [63:0] y_req, input logic cout_req,
                          input logic ovf_req, input logic zero_req);
    int lat;
    issue(op, a, b, cin, tag);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd4);
    check({name, "_y"}, out_y, y_req);
    check({name, "_cout"}, 64'(out_cout), 64'(cout_req));
    check({name, "_ovf"}, 64'(out_ovf), 64'(ovf_req));
    check({name, "_zero"}, 64'(out_zero), 64'(zero_req));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    directed("add_wrap", ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 8'h11,
             64'd0, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf", SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 8'h22,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("addc_seg", ADDC, 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 8'h33,
             64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    directed("subb_small", SUBB, 64'd5, 64'd3, 1'b1, 8'h44,
             64'd1, 1'b1, 1'b0, 1'b0);

    // Back-to-back random traffic.
    trk_first = -1; trk_cnt = 0; trk_en = 1;
    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 8'(8'h50 + i));
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    trk_en = 0;
    check("b2b_count", 64'(trk_cnt), 64'd8);
    check("b2b_consecutive", 64'(trk_last - trk_first + 1), 64'd8);

    // Fill the pipe with downstream blocked, then hold for six cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 8'(8'h60 + i));
    end
    in_valid = 1'b1;
    in_op    = SUB;
    in_a     = 64'd100;
    in_b     = 64'd200;
    in_cin   = 1'b0;
    in_tag   = 8'h64;
    for (int i = 0; i < 6; i++) begin
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_y", out_y, sb_q[0].y);
      check("stall_out_tag", 64'(out_tag), 64'(sb_q[0].tag));
      @(posedge clk); #1;
    end
    trk_first = -1; trk_cnt = 0; trk_en = 1;
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    trk_en = 0;
    check("drain_count", 64'(trk_cnt), 64'd5);
    check("drain_consecutive", 64'(trk_last - trk_first + 1), 64'd5);

    // Reset with three operations in flight, oldest already at the output.
    for (int i = 0; i < 3; i++) begin
      issue(ADD, 64'(i + 1), 64'd10, 1'b0, 8'(8'h70 + i));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("inflight_out_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_clear_out_valid", 64'(out_valid), 64'd0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("in_reset_out_valid", 64'(out_valid), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    directed("post_reset", ADD, 64'd7, 64'd8, 1'b0, 8'h77,
             64'd15, 1'b0, 1'b0, 1'b0);

    repeat (6) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
